max_unpool16: RTL and testbench
===============================

Name: max_unpool16

Overview:
- Max-unpooling expander: the inverse of the 16-input signed max/argmax tree.
- Accepts one packed {index, value} word per pooling window, as produced by the max tree. Emits the reconstructed 16-element window serially, one element per cycle. The element at position index carries value; all other positions carry zero.
- Sits in the npu_core backward/upsample path between the pooled-result buffer and the feature-map writer.

Parameters:
- Data_Width, 8, width of one data element (two's complement).
- Index_Width, 16, width of the index field; bits [3:0] select the window lane.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  Index_Width+Data_Width  packed word: {index[Index_Width-1:0], value[Data_Width-1:0]}, index in the MSBs.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- out_data  output  Data_Width  current window element.
- out_idx  output  4  lane number of out_data (0..15).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_last  output  1  high with out_valid on lane 15.
- idx_err  output  1  one-cycle pulse on a bad index; only with the optional feature, tied 0 otherwise.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset (rst high at a clk edge):
  - state=IDLE, lane counter=0.
  - out_valid=0, out_last=0, idx_err=0, out_data=0, out_idx=0.
  - Latched index and value cleared.
  - Takes priority over everything, including mid-window; the partial window is discarded with no further output.
- States: IDLE, EMIT.
- in_ready is combinational: (state==IDLE) || (state==EMIT && out_last && out_ready). It is 1 in the first cycle after reset release.
- Accept: in_valid && in_ready at an edge.
  - Latch lane=in_data[Data_Width+3:Data_Width] and value=in_data[Data_Width-1:0].
  - Counter=0; state=EMIT.
- EMIT:
  - out_valid=1, out_idx=counter.
  - out_data = (counter==lane) ? value : 0.
  - out_last = (counter==15).
  - out_data, out_idx and out_last are registered/stable while out_valid && !out_ready (AXI-style hold).
- Advance: on out_valid && out_ready, counter increments.
  - On the lane-15 handshake, if a new word is accepted in the same cycle, state stays EMIT and counter=0. Zero-bubble back-to-back windows.
  - Otherwise state goes to IDLE and out_valid falls next cycle.
- Latency: accept at edge N; lane 0 is valid after edge N (cycle N+1). A full window takes 16 cycles with out_ready held high.
- Throughput: 1 window / 16 cycles sustained.
- Value handling:
  - Value is passed bit-exact; no sign handling is needed.
  - Value 0 at the lane gives an all-zero window, which is legal.
  - A negative value (e.g. 8'h80) appears unchanged at its lane.
- in_valid while in_ready=0: the word must be held by the sender; no data is lost and there is no duplicate accept.

Optional Feature:
- Macro: MAX_UNPOOL16_IDX_CHK_EN.
- Defined: on accept, if in_data[Index_Width+Data_Width-1:Data_Width+4] != 0:
  - idx_err pulses high for exactly one cycle, the cycle after the accept.
  - The window is emitted with all 16 lanes zero.
- Undefined: upper index bits are ignored; only bits [3:0] select the lane; idx_err is constant 0.

Test Plan:
- Reset then single word {16'h0005, 8'h7F}, out_ready=1:
  - 16 beats; lane 5 = 8'h7F, others 0.
  - out_last only on beat 16.
  - in_ready 0 during beats 1-15.
- Back-to-back {16'h0000,8'h80} then {16'h000F,8'h01} with in_valid held:
  - 32 consecutive valid beats with no bubble.
  - Beat 1 = 8'h80; beat 32 = 8'h01.
- Backpressure: out_ready toggling 1,0,0,1 on a {16'h0003,8'h22} window:
  - out_data/out_idx stable while stalled.
  - Exactly 16 handshakes, lane 3 = 8'h22.
- rst asserted at beat 7 of a window:
  - Next cycle out_valid=0, counter 0, in_ready=1.
  - A following word emits a clean 16-beat window.
- With MAX_UNPOOL16_IDX_CHK_EN, word {16'h0013, 8'h55}:
  - idx_err one-cycle pulse; all 16 beats zero.
  - Without the macro: lane 3 = 8'h55, idx_err=0.

Source files
------------

// File: rtl/max_unpool16.sv
// max_unpool16 -- 16-lane max-unpooling expander.
//
// Takes one packed {index, value} word per pooling window (as produced by the
// 16-input max/argmax tree) and replays the window serially, one element per
// cycle. Lane index[3:0] carries value; every other lane carries zero.
//
// Optional feature: define MAX_UNPOOL16_IDX_CHK_EN to flag words whose upper
// index bits are non-zero. Such a word raises idx_err for one cycle and is
// emitted as an all-zero window. Without the macro the upper index bits are
// ignored and idx_err is tied low.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous active-high reset
//   in_data    {index[Index_Width-1:0], value[Data_Width-1:0]}
//   in_valid   in_data valid
//   in_ready   block can accept in_data this cycle (combinational)
//   out_data   current window element
//   out_idx    lane number of out_data (0..15)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data this cycle
//   out_last   high with out_valid on lane 15
//   idx_err    one-cycle pulse on a bad index (optional feature only)
module max_unpool16 #(
  parameter int Data_Width  = 8,
  parameter int Index_Width = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [Index_Width+Data_Width-1:0] in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [Data_Width-1:0]             out_data,
  output logic [3:0]                        out_idx,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              idx_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                state;
  logic [3:0]            counter;
  logic [3:0]            lane;
  logic [Data_Width-1:0] value;

  logic                  accept;
  logic                  advance;
  logic [3:0]            next_count;
  logic [3:0]            in_lane;
  logic [Data_Width-1:0] in_value;
  logic [Data_Width-1:0] acc_value;

  assign in_lane    = in_data[Data_Width+3:Data_Width];
  assign in_value   = in_data[Data_Width-1:0];
  assign next_count = counter + 4'd1;

  // A new word may enter when idle, or on the very cycle the last lane of
  // the current window is handed off (zero-bubble back-to-back windows).
  assign in_ready = (state == IDLE) || ((state == EMIT) && out_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign advance  = out_valid && out_ready;

  // The lane counter is the registered output index.
  assign out_idx = counter;

`ifdef MAX_UNPOOL16_IDX_CHK_EN
  logic in_bad;

  // A bad index suppresses the value so the whole window comes out zero.
  assign in_bad    = |in_data[Index_Width+Data_Width-1:Data_Width+4];
  assign acc_value = in_bad ? {Data_Width{1'b0}} : in_value;

  // Error pulse: high only in the cycle following a bad-index accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_err <= 1'b0;
    end else begin
      idx_err <= accept && in_bad;
    end
  end
`else
  logic unused_upper_index;

  assign unused_upper_index = ^in_data[Index_Width+Data_Width-1:Data_Width+4];
  assign acc_value          = in_value;
  assign idx_err            = 1'b0;
`endif

  // Window FSM: latch the word on accept, then step through lanes 0..15.
  // out_data/out_last are precomputed for the lane that becomes current, so
  // they stay frozen whenever the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= 4'd0;
      lane      <= 4'd0;
      value     <= {Data_Width{1'b0}};
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= {Data_Width{1'b0}};
    end else if (accept) begin
      state     <= EMIT;
      counter   <= 4'd0;
      lane      <= in_lane;
      value     <= acc_value;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      out_data  <= (in_lane == 4'd0) ? acc_value : {Data_Width{1'b0}};
    end else if (advance) begin
      if (out_last) begin
        state     <= IDLE;
        counter   <= 4'd0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_data  <= {Data_Width{1'b0}};
      end else begin
        counter  <= next_count;
        out_last <= (next_count == 4'd15);
        out_data <= (next_count == lane) ? value : {Data_Width{1'b0}};
      end
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_max_unpool16.sv
// Self-checking bench for max_unpool16: directed scenarios followed by random
// words, with a scoreboard queue fed from accepted input words and drained by
// an independent output monitor.
module tb_max_unpool16;

  localparam int DW = 8;
  localparam int IW = 16;
`ifdef MAX_UNPOOL16_IDX_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IW+DW-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  out_data;
  logic [3:0]     out_idx;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last;
  logic           idx_err;

  max_unpool16 #(.Data_Width(DW), .Index_Width(IW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [3:0]    idx;
    logic [DW-1:0] data;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    hs       = 0;
  int    rdy_mode = 0;
  logic  exp_err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: expand one word into its 16-beat window.
  task automatic push_window(input logic [IW+DW-1:0] w);
    int  ln;
    bit  bad;
    beat_t e;
    ln  = int'(w[DW+3:DW]);
    bad = CHK && (w[IW+DW-1:DW+4] != '0);
    for (int i = 0; i < 16; i++) begin
      e.idx  = 4'(i);
      e.last = (i == 15);
      e.data = (!bad && i == ln) ? w[DW-1:0] : '0;
      q.push_back(e);
    end
  endtask

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) begin
        out_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Input monitor: records accepted words into the scoreboard, checks idx_err.
  initial begin
    forever begin
      @(negedge clk);
      chk("idx_err", {31'd0, idx_err}, {31'd0, exp_err});
      if (rst) begin
        q.delete();
        exp_err = 1'b0;
      end else begin
        exp_err = 1'b0;
        if (in_valid && in_ready) begin
          push_window(in_data);
          exp_err = CHK && (in_data[IW+DW-1:DW+4] != '0);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every handshake, checks hold on stall.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [3:0]    prev_idx;
    logic          prev_last;
    beat_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_idx   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
        chk("hold_idx", {28'd0, out_idx}, {28'd0, prev_idx});
        chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (!rst && out_valid && out_ready) begin
        hs++;
        if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
          chk("beat_idx", {28'd0, out_idx}, {28'd0, e.idx});
          chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      prev_stall = !rst && out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end
  end

  // Present a word and hold it until accepted; returns at posedge+1 after
  // the accepting edge with in_valid still high.
  task automatic send_word(input logic [IW+DW-1:0] w);
    bit acc;
    acc = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = !out_valid;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h0;
    logic [IW+DW-1:0] w;

    // Reset and check the reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
    @(posedge clk);
    #1;

    // Single window, lane 5; in_ready stays low until the last beat.
    rdy_mode = 0;
    send_word({16'h0005, 8'h7F});
    in_valid = 1'b0;
    for (int b = 1; b <= 16; b++) begin
      @(negedge clk);
      chk("t1_in_ready", {31'd0, in_ready}, {31'd0, 1'(b == 16)});
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
    end
    wait_idle();

    // Back-to-back windows with in_valid held: 32 beats, no bubble.
    h0 = hs;
    send_word({16'h0000, 8'h80});
    send_word({16'h000F, 8'h01});
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    @(posedge clk);
    #1;
    chk("b2b_beats", 32'(hs - h0), 32'd32);
    @(negedge clk);
    chk("b2b_done", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure with ready pattern 1,0,0,1.
    rdy_mode = 1;
    h0 = hs;
    send_word({16'h0003, 8'h22});
    in_valid = 1'b0;
    wait_idle();
    chk("bp_handshakes", 32'(hs - h0), 32'd16);

    // Reset at beat 7, then a clean window.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_word({16'h0009, 8'hA5});
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_idx", {28'd0, out_idx}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    h0 = hs;
    send_word({16'h000C, 8'h3C});
    in_valid = 1'b0;
    wait_idle();
    chk("midrst_clean", 32'(hs - h0), 32'd16);

    // Upper index bits set: bad index only with the check enabled.
    send_word({16'h0013, 8'h55});
    in_valid = 1'b0;
    wait_idle();

    // Random words, gaps and downstream stalls.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      w = IW'($urandom);
      if ($urandom_range(0, 1) == 0) w[IW+DW-1:DW+4] = '0;
      w[DW-1:0] = DW'($urandom);
      send_word(w);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
